capping_controller: RTL and testbench
=====================================

// Module: capping_controller
// PURPOSE
//   Parametrised cork-capping station controller for the bottling line.
//   Seals a positioned bottle with a timed seal_en pulse and keeps a cork
//   magazine stock count with saturating refill. It flags low stock and
//   latches coded faults: empty magazine, bottle lost mid-seal, outlet jam.
//   Sits between the filling stage and the conveyor outlet; done feeds the
//   line sequencer.
// PARAMETERS
//   STOCK_W      8    width of the cork stock counter and refill_qty
//   MAX_STOCK    200  magazine capacity; stock saturates here (< 2**STOCK_W)
//   INIT_STOCK   0    stock value loaded on reset (<= MAX_STOCK)
//   LOW_LEVEL    10   low_stock asserted when stock <= LOW_LEVEL
//   SEAL_CYCLES  4    seal_en high time in clk cycles (>= 1)
//   JAM_CYCLES   32   max cycles a sealed bottle may remain at the head (>= 2)
// PORTS
//   clk          in   1        clock, rising edge
//   reset        in   1        asynchronous, active-high
//   bottle_in    in   1        bottle present at capping head
//   pos_ok       in   1        bottle correctly positioned under head
//   ack_alarm    in   1        operator acknowledge, level-sampled
//   refill_valid in   1        refill batch offered
//   refill_qty   in   STOCK_W  corks in offered batch
//   refill_ready out  1        refill can be accepted this cycle
//   seal_en      out  1        capping actuator drive
//   done         out  1        one-cycle pulse: bottle sealed
//   stock        out  STOCK_W  current cork count
//   low_stock    out  1        stock <= LOW_LEVEL
//   alarm        out  1        in ALARM state
//   fault_code   out  2        00 none, 01 EMPTY, 10 POS_LOST, 11 JAM
// BEHAVIOUR
//   Reset: state IDLE; stock = INIT_STOCK; seal_en, done, alarm = 0;
//     fault_code = 00; counters = 0. All outputs come from registers except
//     refill_ready, low_stock and alarm, which decode state/stock.
//   IDLE
//     - stock==0 and no refill accepted -> ALARM, fault EMPTY.
//     - stock>0 & bottle_in & pos_ok -> SEAL: consume 1 cork, load
//       seal_cnt = SEAL_CYCLES-1.
//   SEAL
//     - seal_en = 1 every cycle in SEAL; exactly SEAL_CYCLES cycles.
//     - pos_ok==0 on any SEAL cycle -> ALARM, fault POS_LOST; cork is not
//       refunded; seal_en drops the next cycle.
//     - Otherwise, at seal_cnt==0 -> RELEASE, with done=1 for that one cycle.
//   RELEASE
//     - Waits for bottle_in==0, then -> IDLE. This blocks a double seal.
//     - Counts cycles; bottle_in still 1 after JAM_CYCLES -> ALARM, fault JAM.
//   ALARM
//     - alarm = 1; fault_code holds its value.
//     - Exit to IDLE on ack_alarm & cleared condition: EMPTY needs stock>0;
//       POS_LOST and JAM need bottle_in==0. fault_code -> 00 on exit.
//     - ack_alarm with the condition not cleared is ignored (stays ALARM).
//   Refill
//     - refill_ready = 1 in IDLE and ALARM, else 0.
//     - Accept on refill_valid & refill_ready.
//     - stock_next = min(stock + qty - consume, MAX_STOCK), computed in
//       STOCK_W+1 bits.
//     - Accept and consume in the same cycle both apply.
//     - In IDLE with stock==0, an accepted refill suppresses the EMPTY alarm;
//       the seal start waits for the next cycle.
//   reset mid-SEAL: seal_en drops immediately (async); consumed cork is lost,
//     stock reloads INIT_STOCK.
// STRUCTURE
//   capping_pkg: state encodings (IDLE, SEAL, RELEASE, ALARM, 2 bits) and
//     fault codes (F_NONE, F_EMPTY, F_POS_LOST, F_JAM).
//   Sub-module cork_stock_counter: saturating add/decrement, low_stock flag.
//   Top holds the FSM, seal and jam timers, and the fault register.
// TESTING
//   1 INIT_STOCK=5, bottle_in=pos_ok=1 -> seal_en high exactly 4 cycles,
//     done 1 pulse, stock 4.
//   2 Stock 0 in IDLE -> alarm=1, fault 01. Refill qty 30 + ack -> IDLE,
//     stock 30.
//   3 pos_ok drops in 2nd SEAL cycle -> alarm, fault 10, stock decremented;
//     ack with bottle_in=1 ignored; ack with bottle_in=0 -> IDLE.
//   4 bottle_in held 1 after done -> fault 11 after 32 RELEASE cycles;
//     no second seal.
//   5 stock 195, refill 20 -> stock 200. Refill 3 with seal start, stock 9 ->
//     11, low_stock 0.
//   6 Async reset asserted mid-SEAL -> seal_en 0 same cycle, stock=INIT_STOCK,
//     state IDLE.

Source files
------------

// File: rtl/capping_pkg.sv
// Shared encodings for the cork-capping station: FSM states and latched fault codes.
package capping_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    SEAL    = 2'b01,
    RELEASE = 2'b10,
    ALARM   = 2'b11
  } state_t;

  typedef enum logic [1:0] {
    F_NONE     = 2'b00,
    F_EMPTY    = 2'b01,
    F_POS_LOST = 2'b10,
    F_JAM      = 2'b11
  } fault_t;

  // Width of a down/up counter able to hold values 0..n-1, never narrower than 1 bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cork_stock_counter.sv
// Cork magazine stock: refill and consume in one cycle, saturating at capacity.
module cork_stock_counter #(
  parameter int STOCK_W    = 8,
  parameter int MAX_STOCK  = 200,
  parameter int INIT_STOCK = 0,
  parameter int LOW_LEVEL  = 10
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               accept,
  input  logic [STOCK_W-1:0] qty,
  input  logic               consume,
  output logic [STOCK_W-1:0] stock,
  output logic               empty,
  output logic               low_stock
);

  localparam logic [STOCK_W:0]   MAX_EXT  = (STOCK_W+1)'(MAX_STOCK);
  localparam logic [STOCK_W-1:0] INIT_VAL = STOCK_W'(INIT_STOCK);
  localparam logic [STOCK_W-1:0] LOW_VAL  = STOCK_W'(LOW_LEVEL);

  logic [STOCK_W-1:0] stock_reg;
  logic [STOCK_W-1:0] stock_next;
  logic [STOCK_W:0]   add_ext;
  logic [STOCK_W:0]   sum_next;

  // One extra bit keeps stock + qty from wrapping before the clamp.
  always_comb begin
    add_ext    = accept ? {1'b0, qty} : '0;
    sum_next   = {1'b0, stock_reg} + add_ext - {{STOCK_W{1'b0}}, consume};
    stock_next = (sum_next > MAX_EXT) ? MAX_EXT[STOCK_W-1:0] : sum_next[STOCK_W-1:0];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stock_reg <= INIT_VAL;
    end else begin
      stock_reg <= stock_next;
    end
  end

  assign stock     = stock_reg;
  assign empty     = (stock_reg == '0);
  assign low_stock = (stock_reg <= LOW_VAL);

endmodule

// File: rtl/capping_controller.sv
// Cork-capping station: timed seal pulse, release/jam supervision and latched faults.
module capping_controller
  import capping_pkg::*;
#(
  parameter int STOCK_W     = 8,
  parameter int MAX_STOCK   = 200,
  parameter int INIT_STOCK  = 0,
  parameter int LOW_LEVEL   = 10,
  parameter int SEAL_CYCLES = 4,
  parameter int JAM_CYCLES  = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               bottle_in,
  input  logic               pos_ok,
  input  logic               ack_alarm,
  input  logic               refill_valid,
  input  logic [STOCK_W-1:0] refill_qty,
  output logic               refill_ready,
  output logic               seal_en,
  output logic               done,
  output logic [STOCK_W-1:0] stock,
  output logic               low_stock,
  output logic               alarm,
  output logic [1:0]         fault_code
);

  localparam int SEAL_W = cnt_width(SEAL_CYCLES);
  localparam int JAM_W  = cnt_width(JAM_CYCLES);
  localparam logic [SEAL_W-1:0] SEAL_LAST = SEAL_W'(SEAL_CYCLES - 1);
  localparam logic [JAM_W-1:0]  JAM_LAST  = JAM_W'(JAM_CYCLES - 1);

  state_t            state_reg;
  fault_t            fault_reg;
  logic [SEAL_W-1:0] seal_cnt_reg;
  logic [JAM_W-1:0]  jam_cnt_reg;
  logic              seal_en_reg;
  logic              done_reg;

  logic accept;
  logic start;
  logic stock_empty;
  logic cleared;

  assign refill_ready = (state_reg == IDLE) || (state_reg == ALARM);
  assign accept       = refill_valid && refill_ready;
  assign start        = (state_reg == IDLE) && !stock_empty && bottle_in && pos_ok;
  // An empty-magazine fault clears with stock; positional faults clear once the bottle is gone.
  assign cleared      = (fault_reg == F_EMPTY) ? !stock_empty : !bottle_in;

  cork_stock_counter #(
    .STOCK_W    (STOCK_W),
    .MAX_STOCK  (MAX_STOCK),
    .INIT_STOCK (INIT_STOCK),
    .LOW_LEVEL  (LOW_LEVEL)
  ) u_stock (
    .clk       (clk),
    .reset     (reset),
    .accept    (accept),
    .qty       (refill_qty),
    .consume   (start),
    .stock     (stock),
    .empty     (stock_empty),
    .low_stock (low_stock)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg    <= IDLE;
      fault_reg    <= F_NONE;
      seal_cnt_reg <= '0;
      jam_cnt_reg  <= '0;
      seal_en_reg  <= 1'b0;
      done_reg     <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          // A refill landing on an empty magazine defers the seal by one cycle instead of alarming.
          if (stock_empty && !accept) begin
            state_reg <= ALARM;
            fault_reg <= F_EMPTY;
          end else if (start) begin
            state_reg    <= SEAL;
            seal_cnt_reg <= SEAL_LAST;
            seal_en_reg  <= 1'b1;
          end
        end
        SEAL: begin
          if (!pos_ok) begin
            state_reg   <= ALARM;
            fault_reg   <= F_POS_LOST;
            seal_en_reg <= 1'b0;
          end else if (seal_cnt_reg == '0) begin
            state_reg   <= RELEASE;
            jam_cnt_reg <= '0;
            seal_en_reg <= 1'b0;
            done_reg    <= 1'b1;
          end else begin
            seal_cnt_reg <= seal_cnt_reg - 1'b1;
          end
        end
        RELEASE: begin
          if (!bottle_in) begin
            state_reg <= IDLE;
          end else if (jam_cnt_reg == JAM_LAST) begin
            state_reg <= ALARM;
            fault_reg <= F_JAM;
          end else begin
            jam_cnt_reg <= jam_cnt_reg + 1'b1;
          end
        end
        ALARM: begin
          if (ack_alarm && cleared) begin
            state_reg <= IDLE;
            fault_reg <= F_NONE;
          end
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign seal_en    = seal_en_reg;
  assign done       = done_reg;
  assign alarm      = (state_reg == ALARM);
  assign fault_code = fault_reg;

endmodule

// File: tb/tb_capping_controller.sv
// Directed bench for capping_controller: seal timing, faults, refill saturation, async reset.
module tb_capping_controller;

  localparam int STOCK_W = 8;

  logic               clk = 1'b0;
  logic               reset;
  logic               bottle_in;
  logic               pos_ok;
  logic               ack_alarm;
  logic               refill_valid;
  logic [STOCK_W-1:0] refill_qty;
  logic               refill_ready;
  logic               seal_en;
  logic               done;
  logic [STOCK_W-1:0] stock;
  logic               low_stock;
  logic               alarm;
  logic [1:0]         fault_code;

  int n_checks = 0;
  int n_pass   = 0;
  int seal_hi;
  int done_hi;

  capping_controller #(
    .STOCK_W     (STOCK_W),
    .MAX_STOCK   (200),
    .INIT_STOCK  (5),
    .LOW_LEVEL   (10),
    .SEAL_CYCLES (4),
    .JAM_CYCLES  (32)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .bottle_in    (bottle_in),
    .pos_ok       (pos_ok),
    .ack_alarm    (ack_alarm),
    .refill_valid (refill_valid),
    .refill_qty   (refill_qty),
    .refill_ready (refill_ready),
    .seal_en      (seal_en),
    .done         (done),
    .stock        (stock),
    .low_stock    (low_stock),
    .alarm        (alarm),
    .fault_code   (fault_code)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_checks++;
    assert (observed === expected) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
    $display("check %-22s observed %0d expected %0d", tag, observed, expected);
  endtask

  // Full seal of one bottle followed by its removal; leaves the DUT in IDLE.
  task automatic do_seal();
    bottle_in = 1'b1;
    pos_ok    = 1'b1;
    repeat (5) tick();
    bottle_in = 1'b0;
    tick();
  endtask

  initial begin
    reset = 1'b1; bottle_in = 1'b0; pos_ok = 1'b0; ack_alarm = 1'b0;
    refill_valid = 1'b0; refill_qty = '0;
    tick(); tick();
    reset = 1'b0;
    check("rst_seal_en", seal_en, 0);
    check("rst_done", done, 0);
    check("rst_alarm", alarm, 0);
    check("rst_fault", fault_code, 0);
    check("rst_stock", stock, 5);
    check("rst_low_stock", low_stock, 1);
    check("rst_refill_ready", refill_ready, 1);

    // Normal seal: 4 cycles of seal_en, one done pulse.
    bottle_in = 1'b1; pos_ok = 1'b1;
    seal_hi = 0; done_hi = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (seal_en) seal_hi++;
      if (done) done_hi++;
      if (i == 1) check("seal_refill_ready", refill_ready, 0);
    end
    check("seal_en_cycles", seal_hi, 4);
    check("done_pulses", done_hi, 1);
    check("seal_stock", stock, 4);
    bottle_in = 1'b0;
    tick();
    check("seal_back_idle", refill_ready & ~alarm, 1);

    // Jam: bottle stays after done; alarm only at the 32nd RELEASE cycle.
    bottle_in = 1'b1; pos_ok = 1'b1;
    repeat (5) tick();
    check("jam_done", done, 1);
    seal_hi = 0;
    for (int i = 0; i < 31; i++) begin
      tick();
      if (seal_en) seal_hi++;
    end
    check("jam_no_alarm_31", alarm, 0);
    check("jam_no_reseal", seal_hi, 0);
    tick();
    check("jam_alarm_32", alarm, 1);
    check("jam_fault", fault_code, 3);
    check("jam_stock", stock, 3);
    ack_alarm = 1'b1;
    tick();
    check("jam_ack_ignored", alarm, 1);
    bottle_in = 1'b0;
    tick();
    check("jam_ack_exit", alarm, 0);
    check("jam_fault_clear", fault_code, 0);
    ack_alarm = 1'b0;

    // Position lost in the 2nd SEAL cycle.
    bottle_in = 1'b1; pos_ok = 1'b1;
    tick(); tick();
    pos_ok = 1'b0;
    tick();
    check("pos_alarm", alarm, 1);
    check("pos_fault", fault_code, 2);
    check("pos_seal_en_drop", seal_en, 0);
    check("pos_stock", stock, 2);
    ack_alarm = 1'b1;
    tick();
    check("pos_ack_ignored", alarm, 1);
    check("pos_fault_hold", fault_code, 2);
    bottle_in = 1'b0;
    tick();
    check("pos_ack_exit", alarm, 0);
    ack_alarm = 1'b0;

    // Drain to empty, then EMPTY alarm and refill recovery.
    do_seal();
    do_seal();
    check("drain_stock", stock, 0);
    check("drain_no_alarm_yet", alarm, 0);
    tick();
    check("empty_alarm", alarm, 1);
    check("empty_fault", fault_code, 1);
    ack_alarm = 1'b1;
    tick();
    check("empty_ack_ignored", alarm, 1);
    ack_alarm = 1'b0;
    check("alarm_refill_ready", refill_ready, 1);
    refill_valid = 1'b1; refill_qty = 8'd30;
    tick();
    refill_valid = 1'b0;
    check("empty_refill_stock", stock, 30);
    check("empty_still_alarm", alarm, 1);
    ack_alarm = 1'b1;
    tick();
    ack_alarm = 1'b0;
    check("empty_exit", alarm, 0);
    check("empty_fault_clear", fault_code, 0);

    // Saturating refill.
    refill_valid = 1'b1; refill_qty = 8'd165;
    tick();
    check("refill_195", stock, 195);
    refill_qty = 8'd20;
    tick();
    refill_valid = 1'b0;
    check("refill_sat_200", stock, 200);

    // Reset, then refill and seal start in the same cycle.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rst2_stock", stock, 5);
    refill_valid = 1'b1; refill_qty = 8'd4;
    tick();
    check("refill_9", stock, 9);
    check("low_at_9", low_stock, 1);
    refill_qty = 8'd3; bottle_in = 1'b1; pos_ok = 1'b1;
    tick();
    refill_valid = 1'b0;
    check("refill_consume_11", stock, 11);
    check("low_at_11", low_stock, 0);
    check("seal_started", seal_en, 1);

    // Asynchronous reset mid-SEAL.
    tick();
    check("mid_seal_en", seal_en, 1);
    #2;
    reset = 1'b1;
    #1;
    check("async_seal_en", seal_en, 0);
    check("async_stock", stock, 5);
    check("async_idle", refill_ready & ~alarm, 1);
    bottle_in = 1'b0; pos_ok = 1'b0;
    tick();
    reset = 1'b0;
    tick();
    check("post_rst_alarm", alarm, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
